// File: rtl/load_down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter.
package load_down_counter_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/load_down_counter.sv
// Loadable synchronous down-counter with terminal-count pulse and sticky done.
// Define LOAD_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload on terminal count.
module load_down_counter
  import load_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (ld) begin
      q_d     = data_in;
      state_d = (data_in != '0) ? COUNT : IDLE;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = data_in;
`endif
    end else if (dec && state_q == COUNT) begin
      // COUNT is only entered with a nonzero value, so q_q >= 1 here.
      if (q_q == ONE) begin
        tc_d = 1'b1;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
        q_d = reload_q;
`else
        q_d     = '0;
        state_d = DONE;
`endif
      end else begin
        q_d = q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
`ifdef LOAD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);
  assign tc   = tc_q;
  assign busy = (state_q == COUNT);
  assign done = (state_q == DONE);

endmodule

// File: doc/load_down_counter.md
Name: load_down_counter

Overview:
- Loadable, synchronous down-counter: the decrementing counterpart of the team's loadable up-counter.
- Used as a countdown/timeout engine: software or a controller loads a start value, then `dec` strobes count it toward zero.
- Flags the terminal count with a single-cycle pulse and holds a sticky done status until reloaded.
- Same load/step handshake style as the up-counter so both can share stimulus and a common behavioural model.

Parameters:
- WIDTH, 8, counter and load-data width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; clock clk.
- data_in  input  WIDTH  load value, sampled when ld=1.
- ld  input  1  load strobe; highest priority after reset.
- dec  input  1  decrement enable, level-sensitive, one step per clock.
- q  output  WIDTH  current count (registered).
- zero  output  1  combinational, (q == 0).
- tc  output  1  registered terminal-count pulse, 1 cycle wide.
- busy  output  1  registered, state == COUNT.
- done  output  1  registered, state == DONE; sticky until next ld.

Behaviour:
- All state updates on posedge clk; q changes on the edge after ld/dec are sampled (latency 1).
- Reset (rst=0 at an edge):
  - q=0, tc=0, busy=0, done=0, reload_reg=0, state=IDLE.
  - zero=1 follows q.
  - Applies mid-count with no residual tc.
- Priority: rst > ld > dec > hold.
- FSM states: IDLE, COUNT, DONE.
- ld=1, any state:
  - q <= data_in; reload_reg <= data_in; tc <= 0.
  - state <= COUNT if data_in != 0, else IDLE (loading 0 never produces tc or done).
  - dec is ignored that cycle (ld+dec conflict, load wins).
- COUNT, dec=1, q > 1: q <= q-1; stay COUNT.
- COUNT, dec=1, q == 1:
  - q <= 0; tc <= 1 for exactly that one cycle; state <= DONE.
- COUNT, dec=0: hold q; tc <= 0.
- IDLE or DONE with dec=1:
  - q stays 0 (saturating, no wrap to all-ones); tc stays 0; state unchanged.
- tc is deasserted on every edge not listed above.
- Arithmetic: unsigned, WIDTH bits, no wrap-around possible in the base build.
- Max load value (all ones) counts down fully: 2^WIDTH-1 dec cycles to tc.

Optional Feature:
- Macro: LOAD_DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined: COUNT with dec=1 and q == 1 does the following:
  - q <= reload_reg; tc <= 1 for one cycle; state stays COUNT.
  - done never asserts from counting; periodic tc every reload_reg dec-cycles.
  - ld still overrides and updates reload_reg.
  - ld of 0 still goes to IDLE.
- Undefined: one-shot behaviour as above; reload_reg may be optimised away.

Decomposition:
- Package load_down_counter_pkg:
  - typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t.
  - localparam DEFAULT_WIDTH = 8.
- Single module; no sub-module is natural (datapath is one register plus a decrementer).

Test Plan:
- Reset then idle: rst=0 for 2 clocks, release; dec=1 for 5 clocks -> q=0, zero=1, tc=0, busy=0, done=0 throughout.
- One-shot: ld with data_in=8'h03, then dec=1 continuous -> q sequence 3,2,1,0; tc=1 on the edge q becomes 0 only; done=1 and busy=0 after; q holds 0 with dec still 1.
- Conflict and hold:
  - Load 8'h10, count to 8'h0C, then ld=1,dec=1 with data_in=8'hAA -> q=8'hAA, no decrement that cycle.
  - dec=0 for 3 clocks -> q holds 8'hAA.
- Load zero and mid-count reset:
  - ld data_in=8'h00 -> state IDLE, no tc, done=0.
  - Load 8'h05, dec 2 clocks, rst=0 -> q=0, tc=0, done=0 next edge.
- Auto-reload (macro defined): load 8'h02, dec=1 for 6 clocks -> q 2,1,2,1,2,1; tc pulses on each 1->2 transition (3 pulses); done stays 0.
- Random: 200 cycles random {ld,dec,data_in} with a behavioural model checked on negedge -> q, tc, done, busy match every cycle.
